// File: rtl/tt_seq_pkg.sv
// Shared types and constants for the truth-table sequencer: FSM state,
// default geometry and the dwell-counter width rule.
package tt_seq_pkg;

  localparam int N_IN_DEF  = 3;
  localparam int DWELL_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Counter holds DWELL-1 down to 0; never narrower than one bit.
  function automatic int cnt_width(input int dwell);
    return (dwell <= 1) ? 1 : $clog2(dwell);
  endfunction

  localparam int CNT_W_DEF = cnt_width(DWELL_DEF);

endpackage

// File: rtl/truth_table_sequencer_if.sv
// Control/result bundle between the test/config master and the sequencer.
interface truth_table_sequencer_if #(
  parameter int N_IN = 3
);
  localparam int W  = 1 << N_IN;
  localparam int CW = $clog2(W) + 1;

  // Handshake: start is a one-cycle request taken only while the sequencer
  // is IDLE (abort low); busy covers the sweep, done pulses once with the
  // results; abort cancels at any time and leaves published results intact.
  logic          start;
  logic          abort;
  logic [W-1:0]  expected;
  logic          busy;
  logic          done;
  logic [W-1:0]  table_out;
  logic [CW-1:0] ones_count;
  logic          pass;

  modport master (
    output start, abort, expected,
    input  busy, done, table_out, ones_count, pass
  );

  modport slave (
    input  start, abort, expected,
    output busy, done, table_out, ones_count, pass
  );

endinterface

// File: rtl/tt_popcount.sv
// Combinational population count of a WIDTH-bit vector.
module tt_popcount #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]       bits,
  output logic [$clog2(WIDTH):0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + {{$clog2(WIDTH){1'b0}}, bits[i]};
    end
  end

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps an N_IN-input combinational circuit through every input vector,
// samples its output after a dwell, and publishes the truth table.
module truth_table_sequencer
  import tt_seq_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int DWELL = DWELL_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  truth_table_sequencer_if.slave   bus,
  input  logic                     s_in,
  output logic [N_IN-1:0]          vec,
  output state_t                   state_dbg
);

  localparam int W     = 1 << N_IN;
  localparam int CW    = $clog2(W) + 1;
  localparam int CNT_W = cnt_width(DWELL);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL - 1);
  localparam logic [N_IN-1:0]  VEC_LAST = {N_IN{1'b1}};

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [N_IN-1:0]   vec_nx;
  logic [W-1:0]      shadow, shadow_nx;
  logic [W-1:0]      exp_q, exp_nx;
  logic              publish;
  logic [CW-1:0]     pop;

  logic [W-1:0]      table_q;
  logic [CW-1:0]     ones_q;
  logic              pass_q;

  // Popcount sees the shadow including the final sample, so results are
  // registered on the same edge that enters DONE.
  tt_popcount #(.WIDTH(W)) u_popcount (
    .bits  (shadow_nx),
    .count (pop)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    vec_nx    = vec;
    shadow_nx = shadow;
    exp_nx    = exp_q;
    publish   = 1'b0;
    case (state)
      IDLE: begin
        vec_nx = '0;
        if (bus.start && !bus.abort) begin
          state_nx  = APPLY;
          cnt_nx    = CNT_LOAD;
          exp_nx    = bus.expected;
          shadow_nx = '0;
        end
      end
      APPLY: begin
        if (bus.abort) begin
          state_nx = IDLE;
          vec_nx   = '0;
        end else if (cnt == '0) begin
          shadow_nx[vec] = s_in;
          if (vec != VEC_LAST) begin
            vec_nx = vec + N_IN'(1);
            cnt_nx = CNT_LOAD;
          end else begin
            state_nx = DONE;
            vec_nx   = '0;
            publish  = 1'b1;
          end
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      DONE: begin
        state_nx = IDLE;
        vec_nx   = '0;
      end
      default: begin
        state_nx = IDLE;
        vec_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      vec     <= '0;
      shadow  <= '0;
      exp_q   <= '0;
      table_q <= '0;
      ones_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      cnt    <= cnt_nx;
      vec    <= vec_nx;
      shadow <= shadow_nx;
      exp_q  <= exp_nx;
      if (publish) begin
        table_q <= shadow_nx;
        ones_q  <= pop;
        pass_q  <= (shadow_nx == exp_q);
      end
    end
  end

  assign bus.busy       = (state == APPLY);
  assign bus.done       = (state == DONE);
  assign bus.table_out  = table_q;
  assign bus.ones_count = ones_q;
  assign bus.pass       = pass_q;
  assign state_dbg      = state;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: a DWELL=4 and a DWELL=1 instance driven
// by random and directed sweeps, checked against a cycle-level sweep model.
module tb_truth_table_sequencer;
  import tt_seq_pkg::*;

  localparam int N  = 3;
  localparam int W  = 8;
  localparam int D0 = 4;
  localparam int D1 = 1;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  truth_table_sequencer_if #(.N_IN(N)) bus0 ();
  truth_table_sequencer_if #(.N_IN(N)) bus1 ();

  logic         start_r    = 1'b0;
  logic         abort_r    = 1'b0;
  int           sel        = 0;
  logic [W-1:0] expected_r = '0;
  logic [W-1:0] func       = '0;
  logic [N-1:0] vec0, vec1;
  state_t       st0, st1;
  logic         s0, s1;

  assign bus0.start    = start_r & (sel == 0);
  assign bus0.abort    = abort_r & (sel == 0);
  assign bus0.expected = expected_r;
  assign bus1.start    = start_r & (sel == 1);
  assign bus1.abort    = abort_r & (sel == 1);
  assign bus1.expected = expected_r;
  assign s0 = func[vec0];
  assign s1 = func[vec1];

  truth_table_sequencer #(.N_IN(N), .DWELL(D0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .s_in(s0), .vec(vec0), .state_dbg(st0)
  );
  truth_table_sequencer #(.N_IN(N), .DWELL(D1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .s_in(s1), .vec(vec1), .state_dbg(st1)
  );

  logic [N-1:0] vec_m;
  logic         busy_m, done_m, pass_m;
  logic [W-1:0] tab_m;
  logic [3:0]   ones_m;
  state_t       st_m;
  assign vec_m  = (sel == 1) ? vec1 : vec0;
  assign busy_m = (sel == 1) ? bus1.busy : bus0.busy;
  assign done_m = (sel == 1) ? bus1.done : bus0.done;
  assign pass_m = (sel == 1) ? bus1.pass : bus0.pass;
  assign tab_m  = (sel == 1) ? bus1.table_out : bus0.table_out;
  assign ones_m = (sel == 1) ? bus1.ones_count : bus0.ones_count;
  assign st_m   = (sel == 1) ? st1 : st0;

  // ---------------- scoreboard ----------------
  int           n_cmp = 0;
  int           n_err = 0;
  logic [W-1:0] pub_tab[2];
  int           pub_ones[2];
  logic         pub_pass[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s dut%0d t=%0t got=%0h want=%0h", tag, sel, $time, got, want);
    end
  endtask

  function automatic logic [W-1:0] tt_of(input int mode);
    logic [W-1:0] r;
    int a, b, c;
    for (int k = 0; k < W; k++) begin
      a = (k >> 2) & 1;
      b = (k >> 1) & 1;
      c = k & 1;
      r[k] = (mode == 0) ? 1'((a & b) | c) : 1'(a ^ b ^ c);
    end
    return r;
  endfunction

  function automatic int ones_of(input logic [W-1:0] t);
    int n = 0;
    for (int k = 0; k < W; k++) n += int'(t[k]);
    return n;
  endfunction

  task automatic check_results(input string tag);
    check({tag, "_table"}, 32'(tab_m), 32'(pub_tab[sel]));
    check({tag, "_ones"}, 32'(ones_m), 32'(pub_ones[sel]));
    check({tag, "_pass"}, 32'(pass_m), 32'(pub_pass[sel]));
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_vec"}, 32'(vec_m), 0);
    check({tag, "_busy"}, 32'(busy_m), 0);
    check({tag, "_done"}, 32'(done_m), 0);
    check_results(tag);
  endtask

  // ---------------- driver ----------------
  // Cycle t=1 is the first cycle after the accepting edge; vector k owns
  // cycles k*d+1 .. (k+1)*d and done owns cycle 8*d+1.
  task automatic sweep(input logic [W-1:0] f, input logic [W-1:0] e,
                       input int restart_t, input int abort_t, input int rst_t);
    int d, last;
    logic [W-1:0] want_tab;
    d        = (sel == 1) ? D1 : D0;
    last     = W * d + 1;
    want_tab = f;
    @(negedge clk);
    func = f; expected_r = e; start_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
    for (int t = 1; t <= last; t++) begin
      if (t == last) begin
        pub_tab[sel]  = want_tab;
        pub_ones[sel] = ones_of(want_tab);
        pub_pass[sel] = (want_tab == e);
      end
      check("vec", 32'(vec_m), (t < last) ? 32'((t - 1) / d) : 0);
      check("busy", 32'(busy_m), 32'(t < last));
      check("done", 32'(done_m), 32'(t == last));
      check_results("hold");
      if (t == rst_t) begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_vec", 32'(vec_m), 0);
        check("rst_busy", 32'(busy_m), 0);
        check("rst_done", 32'(done_m), 0);
        check("rst_state", 32'(st_m), 32'(IDLE));
        for (int i = 0; i < 2; i++) begin
          pub_tab[i] = '0; pub_ones[i] = 0; pub_pass[i] = 1'b0;
        end
        check_results("rst");
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      start_r = (t == restart_t);
      abort_r = (t == abort_t);
      if (t == abort_t) begin
        @(negedge clk);
        abort_r = 1'b0;
        start_r = 1'b0;
        for (int j = 0; j < W * d; j++) begin
          check_quiet("abort");
          @(negedge clk);
        end
        return;
      end
      if (t < last) @(negedge clk);
    end
    if (start_r) begin
      @(negedge clk);
      start_r = 1'b0;
      check("done_start_ignored", 32'(busy_m), 0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] f, e;
    int r;
    for (int i = 0; i < 2; i++) begin
      pub_tab[i] = '0; pub_ones[i] = 0; pub_pass[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      sel = i;
      #0;
      check_quiet("reset");
      check("reset_state", 32'(st_m), 32'(IDLE));
    end
    sel = 0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // directed sweeps on the DWELL=4 instance
    sweep(tt_of(0), 8'hEA, -1, -1, -1);
    sweep(tt_of(0), 8'hEB, -1, -1, -1);
    sweep(8'hFF, 8'hFF, -1, -1, -1);
    sweep(tt_of(0), 8'hEA, -1, -1, -1);
    sweep(8'($urandom), 8'($urandom), -1, 5 * D0 + 1, -1);
    sweep(tt_of(0), 8'hEA, 3 * D0 + 1, -1, -1);

    // start and abort together in IDLE
    @(negedge clk);
    start_r = 1'b1; abort_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0; abort_r = 1'b0;
    for (int j = 0; j < 6; j++) begin
      check_quiet("start_abort");
      @(negedge clk);
    end

    // asynchronous reset mid-sweep, then a fresh full sweep
    sweep(8'($urandom), 8'($urandom), -1, -1, 6 * D0 + 1);
    sweep(8'($urandom), 8'($urandom), -1, -1, -1);

    // randomized sweeps
    for (int n = 0; n < 8; n++) begin
      f = 8'($urandom);
      e = ($urandom_range(0, 1) == 1) ? f : 8'($urandom);
      r = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(1, W * D0 + 1));
      sweep(f, e, r, -1, -1);
    end

    // DWELL=1 instance
    sel = 1;
    #0;
    sweep(tt_of(1), 8'h96, -1, -1, -1);
    check("dw1_ones", 32'(ones_m), 4);
    for (int n = 0; n < 4; n++) begin
      f = 8'($urandom);
      e = ($urandom_range(0, 1) == 1) ? f : 8'($urandom);
      sweep(f, e, -1, (n == 2) ? int'($urandom_range(1, W * D1)) : -1, -1);
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
